hedios_initiator: RTL and testbench

Hardware-side initiator for the Hedios UART debug protocol. It drives a HediosEndpoint from another FPGA or from a self-test harness: it serialises slot-read, action-trigger and device-reset commands onto a UART line and parses the endpoint's replies back into 32-bit responses. It sits between a simple valid/ready command port and the 8N1 UART pins.

---
 rtl/hedios_pkg.sv | 44 ++++
 rtl/hedios_initiator_if.sv | 24 ++
 rtl/hedios_uart_phy.sv | 133 +++++++++++++
 rtl/hedios_initiator.sv | 167 ++++++++++++++++
 tb/tb_hedios_initiator.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/hedios_pkg.sv
// hedios_pkg: wire opcodes, ack byte and shared types for the
// Hedios UART debug initiator.
package hedios_pkg;

  localparam logic [7:0] OP_READ_SLOT    = 8'h01;
  localparam logic [7:0] OP_TRIGGER      = 8'h02;
  localparam logic [7:0] OP_RESET_DEVICE = 8'h03;
  localparam logic [7:0] ACK_BYTE        = 8'hA5;

  typedef enum logic [1:0] {
    CMD_READ_SLOT,
    CMD_TRIGGER,
    CMD_RESET_DEVICE,
    CMD_RESERVED
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND_OP,
    ST_SEND_IDX,
    ST_WAIT_RSP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  function automatic logic [7:0] wire_op(cmd_op_e op);
    logic [7:0] b;
    b = 8'h00;
    unique case (op)
      CMD_READ_SLOT:    b = OP_READ_SLOT;
      CMD_TRIGGER:      b = OP_TRIGGER;
      CMD_RESET_DEVICE: b = OP_RESET_DEVICE;
      default:          b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/hedios_initiator_if.sv
// hedios_initiator_if: command request / response bundle
// between a host and the Hedios initiator.
interface hedios_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_index;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_error;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_index,
    input  cmd_ready, rsp_valid, rsp_data,
    input  rsp_error, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_index,
    output cmd_ready, rsp_valid, rsp_data,
    output rsp_error, busy
  );
endinterface

// File: rtl/hedios_uart_phy.sv
// hedios_uart_phy: 8N1 UART transmitter and receiver,
// bit period CLK_RATE/BAUD_RATE clocks.
module hedios_uart_phy
  import hedios_pkg::*;
#(
  parameter int CLK_RATE  = 100_000_000,
  parameter int BAUD_RATE = 1_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_start,
  input  logic [7:0] tx_byte,
  output logic       tx_done,
  output logic       tx_line,
  input  logic       rx_line,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);

  localparam int DIV  = CLK_RATE / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic          tx_active;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;
  logic          tx_tick;
  logic          tx_load;

  assign tx_tick = tx_active && tx_cnt == DIV_M1;
  assign tx_done = tx_tick && tx_bit == 4'd9;
  // a start arriving with the stop-bit strobe chains frames gaplessly
  assign tx_load = tx_start && (!tx_active || tx_done);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_active <= 1'b0;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
      tx_line   <= 1'b1;
    end else if (tx_load) begin
      tx_active <= 1'b1;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_sh     <= {1'b1, tx_byte};
      tx_line   <= 1'b0;
    end else if (tx_tick) begin
      tx_cnt <= '0;
      if (tx_bit == 4'd9) begin
        tx_active <= 1'b0;
      end else begin
        tx_line <= tx_sh[0];
        tx_sh   <= {1'b1, tx_sh[8:1]};
        tx_bit  <= tx_bit + 4'd1;
      end
    end else if (tx_active) begin
      tx_cnt <= tx_cnt + ONE;
    end
  end

  logic [1:0]    rx_sync;
  logic          rx_s;
  logic          rx_prev;
  rx_state_e     rx_st;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic [7:0]    rx_sh;

  assign rx_s    = rx_sync[1];
  assign rx_byte = rx_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync      <= 2'b11;
      rx_prev      <= 1'b1;
      rx_st        <= RX_IDLE;
      rx_cnt       <= '0;
      rx_bit       <= '0;
      rx_sh        <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_sync      <= {rx_sync[0], rx_line};
      rx_prev      <= rx_s;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      unique case (rx_st)
        RX_IDLE: begin
          if (rx_prev && !rx_s) begin
            rx_st  <= RX_START;
            rx_cnt <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_M1) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_st  <= rx_s ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + ONE;
          end
        end
        RX_DATA: begin
          if (rx_cnt == DIV_M1) begin
            rx_cnt <= '0;
            rx_sh  <= {rx_s, rx_sh[7:1]};
            rx_bit <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_st <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + ONE;
          end
        end
        RX_STOP: begin
          if (rx_cnt == DIV_M1) begin
            rx_st        <= RX_IDLE;
            rx_valid     <= rx_s;
            rx_frame_err <= !rx_s;
          end else begin
            rx_cnt <= rx_cnt + ONE;
          end
        end
        default: rx_st <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/hedios_initiator.sv
// hedios_initiator: Hedios UART command initiator (FSM + response assembly).
// Optional response timeout: define HEDIOS_INITIATOR_TIMEOUT_EN.
module hedios_initiator
  import hedios_pkg::*;
#(
  parameter int CLK_RATE             = 100_000_000,
  parameter int BAUD_RATE            = 1_000_000,
  parameter int SLOT_COUNT           = 5,
  parameter int VARLESS_ACTION_COUNT = 5,
  parameter int TIMEOUT_CYCLES       = 100_000
) (
  input  logic              clk,
  input  logic              rst_n,
  hedios_initiator_if.slave cmd,
  output logic              tx_line,
  input  logic              rx_line
);

  typedef logic [$clog2(TIMEOUT_CYCLES + 1)-1:0] tmo_t;

  state_e      state;
  state_e      state_nx;
  cmd_op_e     op_in;
  cmd_op_e     op_q;
  logic [7:0]  idx_q;
  logic [1:0]  byte_cnt;
  logic [31:0] data_q;
  logic        err_q;
  logic        valid_q;
  logic        accept;
  logic        cmd_bad;
  logic        is_read;
  logic        last_byte;
  logic        timeout;
  logic        tx_start;
  logic [7:0]  tx_byte;
  logic        tx_done;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        rx_frame_err;

  hedios_uart_phy #(
    .CLK_RATE (CLK_RATE),
    .BAUD_RATE(BAUD_RATE)
  ) u_phy (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_start    (tx_start),
    .tx_byte     (tx_byte),
    .tx_done     (tx_done),
    .tx_line     (tx_line),
    .rx_line     (rx_line),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_frame_err(rx_frame_err)
  );

  assign op_in     = cmd_op_e'(cmd.cmd_op);
  assign accept    = cmd.cmd_valid && state == ST_IDLE;
  assign is_read   = op_q == CMD_READ_SLOT;
  assign last_byte = rx_valid && (!is_read || byte_cnt == 2'd3);

  always_comb begin
    cmd_bad = 1'b0;
    unique case (op_in)
      CMD_READ_SLOT:
        cmd_bad = int'({24'd0, cmd.cmd_index}) >= SLOT_COUNT;
      CMD_TRIGGER:
        cmd_bad = int'({24'd0, cmd.cmd_index}) >= VARLESS_ACTION_COUNT;
      CMD_RESET_DEVICE:
        cmd_bad = 1'b0;
      default:
        cmd_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:
        if (accept) state_nx = cmd_bad ? ST_DONE : ST_SEND_OP;
      ST_SEND_OP:
        if (tx_done) state_nx = ST_SEND_IDX;
      ST_SEND_IDX:
        if (tx_done) state_nx = ST_WAIT_RSP;
      ST_WAIT_RSP:
        if (rx_frame_err || last_byte || timeout) state_nx = ST_DONE;
      ST_DONE:
        state_nx = ST_IDLE;
      default:
        state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_start      = 1'b0;
    tx_byte       = idx_q;
    cmd.cmd_ready = state == ST_IDLE;
    cmd.busy      = state != ST_IDLE;
    unique case (state)
      ST_IDLE: begin
        tx_start = accept && !cmd_bad;
        tx_byte  = wire_op(op_in);
      end
      ST_SEND_OP: tx_start = tx_done;
      default: ;
    endcase
  end

  // response registers stay valid after DONE until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= CMD_READ_SLOT;
      idx_q    <= '0;
      byte_cnt <= '0;
      data_q   <= '0;
      err_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= state == ST_DONE;
      if (accept) begin
        op_q     <= op_in;
        idx_q    <= (op_in == CMD_RESET_DEVICE) ? 8'h00 : cmd.cmd_index;
        byte_cnt <= '0;
        data_q   <= '0;
        err_q    <= cmd_bad;
      end else if (state == ST_WAIT_RSP) begin
        if (rx_frame_err || timeout ||
            (rx_valid && !is_read && rx_byte != ACK_BYTE)) begin
          err_q  <= 1'b1;
          data_q <= '0;
        end else if (rx_valid && is_read) begin
          data_q[8*byte_cnt +: 8] <= rx_byte;
          byte_cnt <= byte_cnt + 2'd1;
        end
      end
    end
  end

  assign cmd.rsp_valid = valid_q;
  assign cmd.rsp_data  = data_q;
  assign cmd.rsp_error = err_q;

`ifdef HEDIOS_INITIATOR_TIMEOUT_EN
  tmo_t tmo_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= '0;
    else if (state != ST_WAIT_RSP || rx_valid)
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + tmo_t'(1);
  end

  assign timeout = state == ST_WAIT_RSP &&
                   tmo_cnt == tmo_t'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_hedios_initiator.sv
// tb_hedios_initiator: directed bench with a UART endpoint model
// for the Hedios initiator.
module tb_hedios_initiator;

  localparam int DIV = 100;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_line;
  logic tx_line;

  always #5 clk = ~clk;

  hedios_initiator_if cif();

  hedios_initiator #(
    .CLK_RATE            (100_000_000),
    .BAUD_RATE           (1_000_000),
    .SLOT_COUNT          (5),
    .VARLESS_ACTION_COUNT(5),
    .TIMEOUT_CYCLES      (5000)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (cif.slave),
    .tx_line(tx_line),
    .rx_line(rx_line)
  );

  int          n_chk = 0;
  int          n_pass = 0;
  int          cyc = 0;
  int          rsp_cnt = 0;
  int          rsp_cyc = 0;
  int          tx_low = 0;
  logic [31:0] rsp_d = '0;
  logic        rsp_e = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!tx_line) tx_low <= tx_low + 1;
    if (cif.rsp_valid) begin
      rsp_cnt <= rsp_cnt + 1;
      rsp_cyc <= cyc;
      rsp_d   <= cif.rsp_data;
      rsp_e   <= cif.rsp_error;
    end
  end

  initial begin
    repeat (95000) @(posedge clk);
    $display("FAIL watchdog: got cycle %0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] idx,
                          output int acc);
    @(negedge clk);
    chk("ready_before_cmd", cif.cmd_ready, 1);
    cif.cmd_valid = 1'b1;
    cif.cmd_op    = op;
    cif.cmd_index = idx;
    acc = cyc;
    @(negedge clk);
    cif.cmd_valid = 1'b0;
  endtask

  task automatic tx_get(input string tag, output logic [7:0] b);
    b = 8'h00;
    for (int i = 0; i < 5000 && tx_line; i++) @(negedge clk);
    chk({tag, "_start"}, tx_line, 0);
    repeat (DIV / 2) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      repeat (DIV) @(negedge clk);
      b = {tx_line, b[7:1]};
    end
    repeat (DIV) @(negedge clk);
    chk({tag, "_stop"}, tx_line, 1);
  endtask

  task automatic uart_send(input logic [7:0] b, input logic stop);
    rx_line = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx_line = b[k];
      repeat (DIV) @(negedge clk);
    end
    rx_line = stop;
    repeat (DIV) @(negedge clk);
    rx_line = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic wait_rsp(input string tag, input int n0, input int lim);
    for (int i = 0; i < lim && rsp_cnt == n0; i++) @(negedge clk);
    @(negedge clk);
    chk({tag, "_rsp_seen"}, rsp_cnt, n0 + 1);
  endtask

  initial begin
    int         acc;
    int         n0;
    int         t0;
    logic [7:0] b;

    rst_n         = 1'b0;
    rx_line       = 1'b1;
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = 2'd0;
    cif.cmd_index = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx_line, 1);
    chk("rst_busy", cif.busy, 0);
    chk("rst_valid", cif.rsp_valid, 0);
    chk("rst_err", cif.rsp_error, 0);
    chk("rst_data", cif.rsp_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", cif.cmd_ready, 1);

    // READ_SLOT 2
    n0 = rsp_cnt;
    send_cmd(2'd0, 8'd2, acc);
    chk("rd_start_next_cycle", tx_line, 0);
    chk("rd_busy", cif.busy, 1);
    chk("rd_not_ready", cif.cmd_ready, 0);
    tx_get("rd_op", b);
    chk("rd_op_byte", b, 8'h01);
    tx_get("rd_idx", b);
    chk("rd_idx_byte", b, 8'h02);
    repeat (DIV) @(negedge clk);
    uart_send(8'h78, 1'b1);
    uart_send(8'h56, 1'b1);
    uart_send(8'h34, 1'b1);
    uart_send(8'h12, 1'b1);
    wait_rsp("rd", n0, 200);
    chk("rd_data", rsp_d, 32'h12345678);
    chk("rd_err", rsp_e, 0);
    chk("rd_hold_data", cif.rsp_data, 32'h12345678);
    chk("rd_idle_busy", cif.busy, 0);

    // local error: slot index out of range
    n0 = rsp_cnt;
    t0 = tx_low;
    send_cmd(2'd0, 8'd5, acc);
    wait_rsp("badidx", n0, 20);
    chk("badidx_latency", rsp_cyc - acc, 2);
    chk("badidx_err", rsp_e, 1);
    chk("badidx_data", rsp_d, 0);
    chk("badidx_no_tx", tx_low, t0);

    // local error: reserved op
    n0 = rsp_cnt;
    t0 = tx_low;
    send_cmd(2'd3, 8'd0, acc);
    wait_rsp("badop", n0, 20);
    chk("badop_latency", rsp_cyc - acc, 2);
    chk("badop_err", rsp_e, 1);
    chk("badop_no_tx", tx_low, t0);

    // TRIGGER 4, good ack
    n0 = rsp_cnt;
    send_cmd(2'd1, 8'd4, acc);
    tx_get("tr_op", b);
    chk("tr_op_byte", b, 8'h02);
    tx_get("tr_idx", b);
    chk("tr_idx_byte", b, 8'h04);
    repeat (DIV) @(negedge clk);
    uart_send(8'hA5, 1'b1);
    wait_rsp("tr", n0, 200);
    chk("tr_err", rsp_e, 0);
    chk("tr_data", rsp_d, 0);

    // TRIGGER 4, bad ack
    n0 = rsp_cnt;
    send_cmd(2'd1, 8'd4, acc);
    tx_get("trb_op", b);
    tx_get("trb_idx", b);
    repeat (DIV) @(negedge clk);
    uart_send(8'h3C, 1'b1);
    wait_rsp("trb", n0, 200);
    chk("trb_err", rsp_e, 1);
    chk("trb_data", rsp_d, 0);

    // RESET_DEVICE, endpoint reply with a zero stop bit
    n0 = rsp_cnt;
    send_cmd(2'd2, 8'h77, acc);
    tx_get("rs_op", b);
    chk("rs_op_byte", b, 8'h03);
    tx_get("rs_idx", b);
    chk("rs_idx_byte", b, 8'h00);
    repeat (DIV) @(negedge clk);
    uart_send(8'hA5, 1'b0);
    wait_rsp("rs", n0, 200);
    chk("rs_frame_err", rsp_e, 1);

    // READ_SLOT 0 recovers normally
    n0 = rsp_cnt;
    send_cmd(2'd0, 8'd0, acc);
    tx_get("rd2_op", b);
    tx_get("rd2_idx", b);
    chk("rd2_idx_byte", b, 8'h00);
    repeat (DIV) @(negedge clk);
    uart_send(8'hEF, 1'b1);
    uart_send(8'hBE, 1'b1);
    uart_send(8'hAD, 1'b1);
    uart_send(8'hDE, 1'b1);
    wait_rsp("rd2", n0, 200);
    chk("rd2_data", rsp_d, 32'hDEADBEEF);
    chk("rd2_err", rsp_e, 0);

    // stray byte while idle
    n0 = rsp_cnt;
    uart_send(8'h55, 1'b1);
    repeat (50) @(negedge clk);
    chk("stray_no_rsp", rsp_cnt, n0);
    chk("stray_ready", cif.cmd_ready, 1);

    // reset in the middle of the opcode byte
    n0 = rsp_cnt;
    send_cmd(2'd0, 8'd1, acc);
    repeat (250) @(negedge clk);
    chk("midrst_tx_low", tx_line, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_high", tx_line, 1);
    chk("midrst_busy", cif.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_ready", cif.cmd_ready, 1);
    t0 = tx_low;
    repeat (2000) @(negedge clk);
    chk("midrst_tx_quiet", tx_low, t0);
    chk("midrst_no_rsp", rsp_cnt, n0);

`ifdef HEDIOS_INITIATOR_TIMEOUT_EN
    n0 = rsp_cnt;
    send_cmd(2'd1, 8'd0, acc);
    tx_get("tmo_op", b);
    tx_get("tmo_idx", b);
    t0 = cyc + DIV / 2;
    wait_rsp("tmo", n0, 6000);
    chk("tmo_err", rsp_e, 1);
    chk("tmo_window",
        (rsp_cyc - t0 >= 4995) && (rsp_cyc - t0 <= 5010), 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
